// File: rtl/acappella_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acappella_pkg
// Description : Shared definitions for the a-cappella SDRAM access path:
//               client indices, arbiter state encoding and bus width defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package acappella_pkg;

    // Bus width defaults for the SDRAMBus command port
    localparam int AW_DEF = 23;
    localparam int DW_DEF = 16;

    // Client index type and the fixed client map
    typedef logic [2:0] cli_idx_t;

    localparam cli_idx_t CLI_LOAD   = 3'd0;
    localparam cli_idx_t CLI_MIX    = 3'd1;
    localparam cli_idx_t CLI_PITCH  = 3'd2;
    localparam cli_idx_t CLI_RECORD = 3'd3;
    localparam cli_idx_t CLI_PLAY   = 3'd4;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage : acappella_pkg
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick3
// Description : Combinational 3-way round-robin picker. The search starts at
//               the requester after the last winner and returns a one-hot
//               grant (all zero when nothing requests).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] grant
);

    // Rotate the search origin to the slot after the previous winner
    always_comb begin
        grant = 3'b000;
        case (last)
            2'd0: begin
                if      (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                if      (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if      (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule : rr_pick3
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Registered one-owner-at-a-time arbiter for the SDRAMBus
//               command port. Play and record have fixed priority, the batch
//               clients share the remaining slots round-robin, and a watchdog
//               forces an error completion if the bus never finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import acappella_pkg::*;
#(
    parameter int NCLI    = 5,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCLI-1:0]      cli_read,
    input  logic [NCLI-1:0]      cli_write,
    input  logic [NCLI*AW-1:0]   cli_addr,
    input  logic [NCLI*DW-1:0]   cli_writedata,
    output logic [DW-1:0]        cli_readdata,
    output logic [NCLI-1:0]      cli_done,
    output logic [NCLI-1:0]      cli_err,
    output logic                 sdram_read,
    output logic                 sdram_write,
    output logic [AW-1:0]        sdram_addr,
    output logic [DW-1:0]        sdram_writedata,
    input  logic [DW-1:0]        sdram_readdata,
    input  logic                 sdram_finished
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;

    logic [AW-1:0]    w_addr_arr  [NCLI];
    logic [DW-1:0]    w_wdata_arr [NCLI];

    logic [NCLI-1:0]  w_req;
    logic [NCLI-1:0]  w_mask;
    logic [NCLI-1:0]  w_req_m;
    logic [NCLI-1:0]  w_grant_oh;
    logic [2:0]       w_rr_grant;
    cli_idx_t         w_pick;
    logic             w_any;

    cli_idx_t         r_grant;
    logic             r_is_write;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [1:0]       r_rr_last;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_timeout;
    logic [DW-1:0]    r_rdata;
    logic [NCLI-1:0]  r_done;
    logic [NCLI-1:0]  r_err;

    // Split the packed client buses into per-client entries
    for (genvar gi = 0; gi < NCLI; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = cli_addr[gi*AW +: AW];
        assign w_wdata_arr[gi] = cli_writedata[gi*DW +: DW];
    end

    // A client that just completed may still hold its request during GAP
    assign w_req      = cli_read | cli_write;
    assign w_grant_oh = NCLI'(1) << r_grant;
    assign w_mask     = (r_state == ST_GAP) ? w_grant_oh : '0;
    assign w_req_m    = w_req & ~w_mask;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_timeout  = (w_cnt_inc == CW'(TIMEOUT));

    rr_pick3 u_rr_pick3 (
        .req   (w_req_m[2:0]),
        .last  (r_rr_last),
        .grant (w_rr_grant)
    );

    // Priority overlay: play, then record, then the round-robin batch winner
    always_comb begin
        w_pick = CLI_LOAD;
        w_any  = 1'b1;
        if (w_req_m[CLI_PLAY]) begin
            w_pick = CLI_PLAY;
        end else if (w_req_m[CLI_RECORD]) begin
            w_pick = CLI_RECORD;
        end else if (|w_req_m[2:0]) begin
            if (w_rr_grant[0])      w_pick = CLI_LOAD;
            else if (w_rr_grant[1]) w_pick = CLI_MIX;
            else                    w_pick = CLI_PITCH;
        end else begin
            w_any = 1'b0;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: arbitrate from IDLE or GAP, leave BUSY on finish or watchdog
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_next = ST_BUSY;
            ST_BUSY: if (sdram_finished || w_timeout) w_state_next = ST_GAP;
            ST_GAP:  w_state_next = w_any ? ST_BUSY : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Command outputs come only from latched values and are zero outside BUSY
    always_comb begin
        sdram_read      = 1'b0;
        sdram_write     = 1'b0;
        sdram_addr      = '0;
        sdram_writedata = '0;
        if (r_state == ST_BUSY) begin
            sdram_read      = ~r_is_write;
            sdram_write     = r_is_write;
            sdram_addr      = r_addr;
            sdram_writedata = r_wdata;
        end
    end

    // Grant latch, watchdog counter and completion pulses
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant    <= CLI_LOAD;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rr_last  <= 2'd2;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (r_state == ST_BUSY) begin
                r_cnt <= w_cnt_inc;
                if (sdram_finished) begin
                    r_done <= w_grant_oh;
                    if (!r_is_write) r_rdata <= sdram_readdata;
                end else if (w_timeout) begin
                    r_done  <= w_grant_oh;
                    r_err   <= w_grant_oh;
                    r_rdata <= '0;
                end
            end else if (w_any) begin
                // A write wins when a client raises both read and write
                r_grant    <= w_pick;
                r_is_write <= cli_write[w_pick];
                r_addr     <= w_addr_arr[w_pick];
                r_wdata    <= w_wdata_arr[w_pick];
                r_cnt      <= '0;
                if (w_pick <= CLI_PITCH) r_rr_last <= w_pick[1:0];
            end
        end
    end

    assign cli_readdata = r_rdata;
    assign cli_done     = r_done;
    assign cli_err      = r_err;

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed scoreboard bench for sdram_arbiter. Expected commands
//               and completions are queued by the stimulus; a monitor pops
//               and compares whenever the DUT raises a command or a done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int NC = 5;
    localparam int AW = 23;
    localparam int DW = 16;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            at;
        int            gap;
    } cmd_t;

    typedef struct {
        logic [NC-1:0] done;
        logic [NC-1:0] err;
        logic          chk;
        logic [DW-1:0] rd;
        int            at;
    } dn_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NC-1:0]       cli_read;
    logic [NC-1:0]       cli_write;
    logic [NC*AW-1:0]    cli_addr;
    logic [NC*DW-1:0]    cli_writedata;
    logic [DW-1:0]       cli_readdata;
    logic [NC-1:0]       cli_done;
    logic [NC-1:0]       cli_err;
    logic                sdram_read;
    logic                sdram_write;
    logic [AW-1:0]       sdram_addr;
    logic [DW-1:0]       sdram_writedata;
    logic [DW-1:0]       sdram_readdata;
    logic                sdram_finished;

    int        applied     = 0;
    int        miscompares = 0;
    int        cyc         = 0;
    cmd_t      exp_cmd[$];
    dn_t       exp_dn[$];

    int            left [NC];
    int            seq  [NC];
    logic          mrd  [NC];
    logic          mwr  [NC];
    logic [AW-1:0] base [NC];
    logic          resp_en;
    int            busy_n;

    sdram_arbiter #(
        .NCLI    (NC),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (15)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst_n),
        .cli_read        (cli_read),
        .cli_write       (cli_write),
        .cli_addr        (cli_addr),
        .cli_writedata   (cli_writedata),
        .cli_readdata    (cli_readdata),
        .cli_done        (cli_done),
        .cli_err         (cli_err),
        .sdram_read      (sdram_read),
        .sdram_write     (sdram_write),
        .sdram_addr      (sdram_addr),
        .sdram_writedata (sdram_writedata),
        .sdram_readdata  (sdram_readdata),
        .sdram_finished  (sdram_finished)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int at, input int gap);
        cmd_t e;
        e.wr = wr; e.addr = a; e.wd = wd; e.at = at; e.gap = gap;
        exp_cmd.push_back(e);
    endtask

    task automatic push_dn(input logic [NC-1:0] d, input logic [NC-1:0] er, input logic chk,
                           input logic [DW-1:0] rd, input int at);
        dn_t e;
        e.done = d; e.err = er; e.chk = chk; e.rd = rd; e.at = at;
        exp_dn.push_back(e);
    endtask

    task automatic apply_clients();
        for (int i = 0; i < NC; i++) begin
            cli_read[i]  = (left[i] > 0) && mrd[i];
            cli_write[i] = (left[i] > 0) && mwr[i];
            cli_addr[i*AW +: AW]      = base[i] + AW'(seq[i] * 16);
            cli_writedata[i*DW +: DW] = ~cli_addr[i*AW +: DW];
        end
    endtask

    task automatic start(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] b, input int n);
        mrd[i] = rd; mwr[i] = wr; base[i] = b; seq[i] = 0; left[i] = n;
    endtask

    task automatic sync(output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        int   sum;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            sum = 0;
            for (int i = 0; i < NC; i++) sum += left[i];
            if (exp_cmd.size() == 0 && exp_dn.size() == 0 && sum == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_idle", ok, 1);
        if (!ok) begin
            exp_cmd.delete();
            exp_dn.delete();
            for (int i = 0; i < NC; i++) left[i] = 0;
        end
        repeat (3) @(negedge clk);
    endtask

    // Client model: hold each request until the cycle after its done
    initial begin
        logic [NC-1:0] dseen;
        for (int i = 0; i < NC; i++) begin
            left[i] = 0; seq[i] = 0; mrd[i] = 1'b0; mwr[i] = 1'b0; base[i] = '0;
        end
        apply_clients();
        forever begin
            @(negedge clk);
            dseen = cli_done;
            @(posedge clk);
            #2;
            for (int i = 0; i < NC; i++) begin
                if (dseen[i] && left[i] > 0) begin
                    left[i]--;
                    seq[i]++;
                end
            end
            apply_clients();
        end
    end

    // SDRAMBus model: finishes in the fourth command cycle, data = addr + 0xBDEF
    initial begin
        sdram_finished = 1'b0;
        sdram_readdata = '0;
        busy_n         = 0;
        forever begin
            @(posedge clk);
            #1;
            busy_n = (sdram_read || sdram_write) ? busy_n + 1 : 0;
            sdram_finished = resp_en && (busy_n == 4);
            sdram_readdata = sdram_finished ? (sdram_addr[DW-1:0] + 16'hBDEF) : '0;
        end
    end

    // Monitor: pop and compare on each new command and each completion
    initial begin
        logic          prev_cmd;
        logic          cmd_now;
        logic          stable;
        logic [40:0]   snap;
        int            low_run;
        cmd_t          ec;
        dn_t           ed;
        prev_cmd = 1'b0;
        stable   = 1'b1;
        snap     = '0;
        low_run  = 0;
        forever begin
            @(negedge clk);
            cmd_now = sdram_read | sdram_write;
            if (cmd_now && !prev_cmd) begin
                if (exp_cmd.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_cmd: got addr 0x%0h expected no command (cycle %0d)",
                             sdram_addr, cyc);
                end else begin
                    ec = exp_cmd.pop_front();
                    check("cmd", {sdram_write, sdram_read, sdram_addr, sdram_writedata},
                          {ec.wr, ~ec.wr, ec.addr, ec.wd});
                    if (ec.at >= 0)  check("cmd_cycle", 64'(cyc), 64'(ec.at));
                    if (ec.gap > 0)  check("cmd_gap", 64'(low_run), 64'(ec.gap));
                end
                snap   = {sdram_write, sdram_read, sdram_addr, sdram_writedata};
                stable = !(sdram_read && sdram_write);
            end else if (cmd_now) begin
                if (snap != {sdram_write, sdram_read, sdram_addr, sdram_writedata} ||
                    (sdram_read && sdram_write))
                    stable = 1'b0;
            end else if (prev_cmd) begin
                check("cmd_stable", stable, 1);
            end

            if (cli_done != '0 || cli_err != '0) begin
                if (exp_dn.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done 0x%0h err 0x%0h expected none (cycle %0d)",
                             cli_done, cli_err, cyc);
                end else begin
                    ed = exp_dn.pop_front();
                    check("done_vec", {cli_done, cli_err}, {ed.done, ed.err});
                    if (ed.chk)     check("readdata", cli_readdata, ed.rd);
                    check("done_cmd_low", cmd_now, 0);
                    if (ed.at >= 0) check("done_cycle", 64'(cyc), 64'(ed.at));
                end
            end

            prev_cmd = cmd_now;
            low_run  = cmd_now ? 0 : low_run + 1;
        end
    end

    // Directed stimulus
    initial begin
        int c0;
        int r;
        rst_n   = 1'b0;
        resp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_cmd",   {sdram_read, sdram_write}, 0);
        check("rst_addr",  sdram_addr, 0);
        check("rst_wdata", sdram_writedata, 0);
        check("rst_done",  {cli_done, cli_err}, 0);
        check("rst_rdata", cli_readdata, 0);

        // Simultaneous requests from 0, 2, 3, 4: order 4, 3, 0, 2
        sync(c0);
        push_cmd(1'b0, 23'h004020, 16'hBFDF, c0 + 1, 0);
        push_cmd(1'b1, 23'h003020, 16'hCFDF, -1, 1);
        push_cmd(1'b0, 23'h000020, 16'hFFDF, -1, 1);
        push_cmd(1'b1, 23'h002020, 16'hDFDF, -1, 1);
        push_dn(5'b10000, 5'b0, 1'b1, 16'hFE0F, c0 + 5);
        push_dn(5'b01000, 5'b0, 1'b0, 16'h0000, -1);
        push_dn(5'b00001, 5'b0, 1'b1, 16'hBE0F, -1);
        push_dn(5'b00100, 5'b0, 1'b0, 16'h0000, -1);
        start(0, 1'b1, 1'b0, 23'h000020, 1);
        start(2, 1'b0, 1'b1, 23'h002020, 1);
        start(3, 1'b0, 1'b1, 23'h003020, 1);
        start(4, 1'b1, 1'b0, 23'h004020, 1);
        wait_idle(200);

        // Fairness: clients 0..2 each make three back-to-back accesses
        sync(c0);
        push_cmd(1'b0, 23'h010000, 16'hFFFF, c0 + 1, 0);
        push_cmd(1'b1, 23'h010100, 16'hFEFF, -1, 1);
        push_cmd(1'b0, 23'h010200, 16'hFDFF, -1, 1);
        push_cmd(1'b0, 23'h010010, 16'hFFEF, -1, 1);
        push_cmd(1'b1, 23'h010110, 16'hFEEF, -1, 1);
        push_cmd(1'b0, 23'h010210, 16'hFDEF, -1, 1);
        push_cmd(1'b0, 23'h010020, 16'hFFDF, -1, 1);
        push_cmd(1'b1, 23'h010120, 16'hFEDF, -1, 1);
        push_cmd(1'b0, 23'h010220, 16'hFDDF, -1, 1);
        push_dn(5'b00001, 5'b0, 1'b1, 16'hBDEF, c0 + 5);
        push_dn(5'b00010, 5'b0, 1'b0, 16'h0000, -1);
        push_dn(5'b00100, 5'b0, 1'b1, 16'hBFEF, -1);
        push_dn(5'b00001, 5'b0, 1'b1, 16'hBDFF, -1);
        push_dn(5'b00010, 5'b0, 1'b0, 16'h0000, -1);
        push_dn(5'b00100, 5'b0, 1'b1, 16'hBFFF, -1);
        push_dn(5'b00001, 5'b0, 1'b1, 16'hBE0F, -1);
        push_dn(5'b00010, 5'b0, 1'b0, 16'h0000, -1);
        push_dn(5'b00100, 5'b0, 1'b1, 16'hC00F, -1);
        start(0, 1'b1, 1'b0, 23'h010000, 3);
        start(1, 1'b0, 1'b1, 23'h010100, 3);
        start(2, 1'b1, 1'b0, 23'h010200, 3);
        wait_idle(300);

        // Single read by client 1
        sync(c0);
        push_cmd(1'b0, 23'h000100, 16'hFEFF, c0 + 1, 0);
        push_dn(5'b00010, 5'b0, 1'b1, 16'hBEEF, c0 + 5);
        start(1, 1'b1, 1'b0, 23'h000100, 1);
        wait_idle(100);

        // Read and write both asserted by client 0: treated as a write
        sync(c0);
        push_cmd(1'b1, 23'h000400, 16'hFBFF, c0 + 1, 0);
        push_dn(5'b00001, 5'b0, 1'b0, 16'h0000, c0 + 5);
        start(0, 1'b1, 1'b1, 23'h000400, 1);
        wait_idle(100);

        // Watchdog: client 2 write never finishes, then a normal read
        sync(c0);
        resp_en = 1'b0;
        push_cmd(1'b1, 23'h000600, 16'hF9FF, c0 + 1, 0);
        push_dn(5'b00100, 5'b00100, 1'b1, 16'h0000, c0 + 16);
        start(2, 1'b0, 1'b1, 23'h000600, 1);
        wait_idle(100);
        resp_en = 1'b1;
        sync(c0);
        push_cmd(1'b0, 23'h000700, 16'hF8FF, c0 + 1, 0);
        push_dn(5'b00010, 5'b0, 1'b1, 16'hC4EF, c0 + 5);
        start(1, 1'b1, 1'b0, 23'h000700, 1);
        wait_idle(100);

        // Reset during a client 3 write; client 4 waits through reset
        resp_en = 1'b0;
        sync(c0);
        push_cmd(1'b1, 23'h000800, 16'hF7FF, c0 + 1, 0);
        start(3, 1'b0, 1'b1, 23'h000800, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        left[3] = 0;
        start(4, 1'b1, 1'b0, 23'h000900, 1);
        #1;
        check("rst_async", {sdram_read, sdram_write, sdram_addr, sdram_writedata,
                            cli_done, cli_err, cli_readdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_en = 1'b1;
        r = cyc;
        push_cmd(1'b0, 23'h000900, 16'hF6FF, r + 1, 0);
        push_dn(5'b10000, 5'b0, 1'b1, 16'hC6EF, r + 5);
        wait_idle(100);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_sdram_arbiter
`default_nettype wire

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAMBus command port between the five SDRAM clients of the a-cappella core: loaddata, mix, pitch, record and play. It replaces the wired-OR bus merge with a registered, one-owner-at-a-time arbiter. Real-time clients (play, record) get fixed priority; batch clients (loaddata, mix, pitch) share the remaining slots round-robin. A watchdog returns an error completion if SDRAMBus never finishes.

## Interface
Parameters:
- NCLI, 5: number of clients. Index 0 loaddata, 1 mix, 2 pitch, 3 record, 4 play.
- AW, 23: address width.
- DW, 16: data width.
- TIMEOUT, 1023: maximum cycles to wait for sdram_finished before forcing an error completion.

Ports:
- i_clk, in, 1: system clock; single clock domain.
- i_rst, in, 1: reset, asynchronous, active-low.
- cli_read, in, NCLI: per-client read request (level).
- cli_write, in, NCLI: per-client write request (level).
- cli_addr, in, NCLI×AW packed: per-client address.
- cli_writedata, in, NCLI×DW packed: per-client write data.
- cli_readdata, out, DW: read data, valid while cli_done is high.
- cli_done, out, NCLI: one-hot one-cycle completion pulse.
- cli_err, out, NCLI: one-cycle pulse coincident with cli_done when the access timed out.
- sdram_read, out, 1: read command to SDRAMBus.
- sdram_write, out, 1: write command to SDRAMBus.
- sdram_addr, out, AW: address to SDRAMBus.
- sdram_writedata, out, DW: write data to SDRAMBus.
- sdram_readdata, in, DW: read data from SDRAMBus.
- sdram_finished, in, 1: one-cycle completion pulse from SDRAMBus.

## Operation
- Client request rule: assert cli_read or cli_write, hold it with stable addr/data until the cycle after cli_done, then drop it or present a new request.
- If both cli_read and cli_write are asserted, the request is treated as a write.
- States:
  - IDLE: arbitrate among active requests.
  - BUSY: command asserted; waiting for completion.
  - GAP: one cycle with the command low; arbitrate again here.
- Arbitration order:
  - Client 4 (play) wins over client 3 (record).
  - Client 3 wins over every batch client.
  - Among clients 0–2, round-robin: search starts at the client after the last batch winner.
  - The round-robin pointer updates only when a batch client is granted. Its reset value is 2, so client 0 is searched first.
- IDLE/GAP with any active request: latch grant index, read/write flag, address and write data; go to BUSY.
- IDLE with no request: stay in IDLE. GAP with no request: go to IDLE.
- BUSY:
  - sdram_read or sdram_write (exactly one) is high.
  - sdram_addr and sdram_writedata carry the latched values.
  - Outputs never change during BUSY, even if the client changes its inputs.
- BUSY and sdram_finished = 1:
  - Latch sdram_readdata (reads) into cli_readdata.
  - Pulse cli_done[grant] on the next cycle.
  - Go to GAP.
- BUSY with the timeout counter reaching TIMEOUT:
  - Pulse cli_done[grant] and cli_err[grant].
  - Set cli_readdata to 0.
  - Go to GAP.
- In GAP, the client just completed is masked from arbitration, because its request may still be asserted that cycle.
- Outside BUSY: sdram_read = sdram_write = 0, and sdram_addr = sdram_writedata = 0.
- Reset values: state IDLE, all outputs 0, counter 0, round-robin pointer 2.

## Timing
- Request first high in cycle 0 with the arbiter in IDLE → command high from cycle 1.
- sdram_finished sampled high in cycle k → cli_done in cycle k+1 (also the GAP cycle) → command low in cycle k+1.
- Next command, if another request is pending, is high from cycle k+2. Minimum one command-low cycle between accesses.
- The timeout counter clears on entry to BUSY and increments each BUSY cycle. On the cycle it equals TIMEOUT the arbiter leaves BUSY; done/err pulse on the following cycle.
- sdram_finished outside BUSY is ignored.
- A request dropped mid-BUSY does not abort the access; completion is still pulsed.
- Reset mid-BUSY: outputs drop to 0 immediately (asynchronously) and no done is pulsed. SDRAMBus must tolerate the abandoned command.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (acappella_pkg) holds:
  - client index constants: CLI_LOAD, CLI_MIX, CLI_PITCH, CLI_RECORD, CLI_PLAY;
  - the arbiter state enum (IDLE/BUSY/GAP);
  - AW/DW defaults.
- One sub-module, rr_pick3: a combinational 3-way round-robin picker taking a request mask and the last winner, returning a one-hot grant. The priority overlay, FSM and watchdog live in sdram_arbiter.

## Test plan
- Single read: client 1 reads 0x000100; SDRAMBus finishes 3 cycles after command with readdata 0xBEEF. Expect:
  - command from cycle 1;
  - cli_done = 5'b00010 at cycle 5 with cli_readdata = 0xBEEF;
  - sdram_read low at cycle 5.
- Simultaneous requests: clients 0, 2, 3 and 4 request in the same cycle. Expect grant order 4, 3, 0, 2, with one GAP cycle between commands.
- Fairness: clients 0–2 request continuously for 9 accesses. Expect grants 0, 1, 2 repeating, no client served twice in a row, and the GAP mask honoured.
- Timeout: with TIMEOUT = 15, sdram_finished is never asserted for a client 2 write. Expect cli_done[2] and cli_err[2] one cycle after the 15th BUSY cycle, cli_readdata = 0, and the next request served normally.
- Reset mid-BUSY: i_rst low during a client 3 write. Expect all outputs 0 immediately and no cli_done. After release, a pending client 4 request is served starting 1 cycle after reset deasserts.
- Read+write conflict: client 0 asserts both. Expect sdram_write = 1 and sdram_read = 0 throughout BUSY.
